// File: rtl/mem_port_arbiter.sv
// Two-requester (MMU data path, VGA DMA) arbiter for the single data-RAM port; one access in flight.
// Optional anti-starvation guard for DMA: define MEM_PORT_ARBITER_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_INIT = 3'((RD_LATENCY > 0) ? (RD_LATENCY - 1) : 0);

    state_t     state;
    logic       owner_dma;
    logic       lat_we;
    logic [2:0] wait_cnt;
    logic       pick_cpu;
    logic       pick_dma;
    logic       finish;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic       force_dma;
    assign force_dma = dma_req && (starve_cnt >= 4'(STARVE_LIMIT));
`endif

    always_comb begin
        pick_dma = 1'b0;
        pick_cpu = 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        pick_dma = dma_req && (!cpu_req || force_dma);
`else
        pick_dma = dma_req && !cpu_req;
`endif
        pick_cpu = cpu_req && !pick_dma;
    end

    // The edge that ends the last data-wait cycle: capture read data and move to DONE.
    assign finish = ((state == ACCESS) && (RD_LATENCY == 0)) ||
                    ((state == WAIT) && (wait_cnt == 3'd0));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            owner_dma  <= 1'b0;
            lat_we     <= 1'b0;
            wait_cnt   <= 3'd0;
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_gnt    <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
            starve_cnt <= 4'd0;
`endif
        end else begin
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (pick_cpu || pick_dma) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        owner_dma <= pick_dma;
                        lat_we    <= pick_cpu && cpu_we;
                        mem_we    <= pick_cpu && cpu_we;
                        mem_addr  <= pick_dma ? dma_addr : cpu_addr;
                        if (pick_cpu) mem_wdata <= cpu_wdata;
                        cpu_gnt   <= pick_cpu;
                        dma_gnt   <= pick_dma;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
                        if (pick_dma)
                            starve_cnt <= 4'd0;
                        else if (dma_req && (starve_cnt != 4'hF))
                            starve_cnt <= starve_cnt + 4'd1;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!finish) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (!finish) wait_cnt <= wait_cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase

            if (finish) begin
                state <= DONE;
                if (owner_dma) begin
                    dma_rvalid <= 1'b1;
                    dma_rdata  <= mem_rdata;
                end else begin
                    cpu_rvalid <= 1'b1;
                    if (!lat_we) cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RD_LATENCY=1 instance with a one-cycle RAM model,
// plus a RD_LATENCY=0 instance sharing the request inputs with a combinational RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0;

    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, busy;
    logic [63:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;

    logic        z_cpu_gnt, z_cpu_rvalid, z_dma_gnt, z_dma_rvalid, z_mem_we, z_busy;
    logic [63:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_f(input logic [63:0] a);
        return (a == 64'h100) ? 64'hDEADBEEF_00000001 : {a[31:0], ~a[31:0]};
    endfunction

    always @(posedge clk) mem_rdata <= ram_f(mem_addr);
    assign z_mem_rdata = ram_f(z_mem_addr);

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LATENCY(1), .STARVE_LIMIT(8)) dut (
        .clk(clk), .aresetn(aresetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LATENCY(0), .STARVE_LIMIT(8)) dut0 (
        .clk(clk), .aresetn(aresetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(z_cpu_gnt), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(z_dma_gnt),
        .dma_rvalid(z_dma_rvalid), .dma_rdata(z_dma_rdata),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_cpu;
        logic [63:0] exp_dma;
    } vec_t;

    // One transaction from an idle arbiter; req driven on a falling edge, so the next rising edge is edge 0.
    task automatic do_txn(input vec_t v);
        int gnt_cyc = 0, rv_cyc = 0, z_rv_cyc = 0, wrong = 0, we_cnt = 0, addr_bad = 0;
        logic busy1 = 1'b0, busy6 = 1'b1;
        if (v.is_dma) begin
            dma_req = 1'b1; dma_addr = v.addr;
            cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '1;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if ((v.is_dma ? dma_gnt : cpu_gnt) && gnt_cyc == 0) gnt_cyc = c;
            if (v.is_dma ? cpu_gnt : dma_gnt) wrong++;
            if ((v.is_dma ? dma_rvalid : cpu_rvalid) && rv_cyc == 0) rv_cyc = c;
            if (v.is_dma ? cpu_rvalid : dma_rvalid) wrong++;
            if ((v.is_dma ? z_dma_rvalid : z_cpu_rvalid) && z_rv_cyc == 0) z_rv_cyc = c;
            if (mem_we) begin
                we_cnt++;
                if (mem_addr !== v.addr || mem_wdata !== v.wdata) addr_bad++;
            end
            if (c <= 2 && mem_addr !== v.addr) addr_bad++;
            if (c == 1) begin
                busy1 = busy;
                cpu_req = 1'b0; dma_req = 1'b0;
            end
            if (c == 6) busy6 = busy;
        end
        chk("gnt_cycle", 64'(gnt_cyc), 64'd1);
        chk("rvalid_cycle", 64'(rv_cyc), 64'd3);
        chk("other_port_quiet", 64'(wrong), 64'd0);
        chk("mem_we_pulses", 64'(we_cnt), 64'(v.we && !v.is_dma));
        chk("mem_addr_wdata", 64'(addr_bad), 64'd0);
        chk("busy_in_access", 64'(busy1), 64'd1);
        chk("busy_idle_after", 64'(busy6), 64'd0);
        chk("cpu_rdata", cpu_rdata, v.exp_cpu);
        chk("dma_rdata", dma_rdata, v.exp_dma);
        chk("lat0_rvalid_cycle", 64'(z_rv_cyc), 64'd2);
        chk("lat0_cpu_rdata", z_cpu_rdata, v.exp_cpu);
        chk("lat0_dma_rdata", z_dma_rdata, v.exp_dma);
    endtask

    vec_t vecs[6];

    initial begin
        int cg, dg, cr, dr, n_rv, pre, mid, dseen, cpu_tot, dma_tot;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF_00000001, 64'h0};
        vecs[1] = '{1'b0, 1'b1, 64'h200, 64'h55, 64'hDEADBEEF_00000001, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 64'h340, 64'h0, 64'hDEADBEEF_00000001, 64'h00000340_FFFFFCBF};
        vecs[3] = '{1'b0, 1'b0, 64'h1234, 64'h0, 64'h00001234_FFFFEDCB, 64'h00000340_FFFFFCBF};
        vecs[4] = '{1'b1, 1'b0, 64'hFFFFFFFF_00000008, 64'h0, 64'h00001234_FFFFEDCB, 64'h00000008_FFFFFFF7};
        vecs[5] = '{1'b0, 1'b1, 64'hABC, 64'h01234567_89ABCDEF, 64'h00001234_FFFFEDCB, 64'h00000008_FFFFFFF7};

        repeat (3) @(negedge clk);
        chk("reset_ctrl_outs", 64'({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, busy}), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_rdata", cpu_rdata | dma_rdata | mem_wdata, 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Simultaneous requests: CPU first, DMA granted from the CPU's DONE cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100;
        dma_req = 1'b1; dma_addr = 64'h340;
        cg = 0; dg = 0; cr = 0; dr = 0; n_rv = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin cg = (cg == 0) ? c : 99; cpu_req = 1'b0; end
            if (dma_gnt) begin dg = (dg == 0) ? c : 99; dma_req = 1'b0; end
            if (cpu_rvalid) begin cr = c; n_rv++; end
            if (dma_rvalid) begin dr = c; n_rv++; end
        end
        chk("both_cpu_gnt_cycle", 64'(cg), 64'd1);
        chk("both_dma_gnt_cycle", 64'(dg), 64'd4);
        chk("both_cpu_rvalid_cycle", 64'(cr), 64'd3);
        chk("both_dma_rvalid_cycle", 64'(dr), 64'd6);
        chk("both_rvalid_count", 64'(n_rv), 64'd2);
        chk("both_cpu_rdata", cpu_rdata, 64'hDEADBEEF_00000001);
        chk("both_dma_rdata", dma_rdata, 64'h00000340_FFFFFCBF);

        // Reset while a DMA read sits in WAIT: everything clears, no completion afterwards.
        dma_req = 1'b1; dma_addr = 64'h340;
        @(negedge clk);
        chk("rst_seq_dma_gnt", 64'(dma_gnt), 64'd1);
        dma_req = 1'b0;
        @(negedge clk);
        chk("rst_seq_busy_in_wait", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_async_ctrl_outs", 64'({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, busy}), 64'd0);
        chk("rst_async_mem_addr", mem_addr, 64'd0);
        chk("rst_async_rdata", cpu_rdata | dma_rdata | mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        n_rv = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dma_rvalid || cpu_rvalid || busy) n_rv++;
        end
        chk("rst_no_stale_rvalid", 64'(n_rv), 64'd0);
        v = '{1'b1, 1'b0, 64'h1234, 64'h0, 64'h0, 64'h00001234_FFFFEDCB};
        do_txn(v);

        // Both requests held continuously for 60 cycles: 20 arbitration slots.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100;
        dma_req = 1'b1; dma_addr = 64'h340;
        pre = 0; mid = 0; dseen = 0; cpu_tot = 0; dma_tot = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                cpu_tot++;
                if (dseen == 0) pre++;
                else if (dseen == 1) mid++;
            end
            if (dma_gnt) begin dma_tot++; dseen++; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (8) @(negedge clk);
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
        chk("starve_cpu_before_dma", 64'(pre), 64'd8);
        chk("starve_cpu_between_dma", 64'(mid), 64'd8);
        chk("starve_dma_grants", 64'(dma_tot), 64'd2);
        chk("starve_cpu_grants", 64'(cpu_tot), 64'd18);
`else
        chk("fixed_cpu_before_dma", 64'(pre), 64'd20);
        chk("fixed_dma_grants", 64'(dma_tot), 64'd0);
        chk("fixed_cpu_grants", 64'(cpu_tot), 64'd20);
`endif
        chk("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
